layer_norm_row_sequencer: RTL and testbench
===========================================

// Module: layer_norm_row_sequencer
// PURPOSE
// Row-level controller for the layer-norm processing element. Buffers one row of N
// S5.10 activations and computes mean and variance on the fly. Obtains inv_std from
// an external rsqrt unit over a req/ack handshake. Then streams x_i, mu, inv_std,
// gamma_i and beta_i into the PE and counts PE results until the row is done.
// PARAMETERS
// X_WIDTH     16  activation width, S5.10 (X_FRAC=10)
// MU_WIDTH    24  mean width to PE, S13.10
// INV_WIDTH   24  inv_std width from rsqrt unit / to PE, S9.14
// VAR_WIDTH   32  unsigned variance to rsqrt unit, U11.20 (frac = 2*X_FRAC)
// LOG2_N      6   log2(row length); N = 1<<LOG2_N, N >= 2
// PE_LAT      6   PE valid_in_pe -> valid_out_pe latency, cycles
// EPS         1   epsilon, in VAR LSBs (2^-20), used only with LN_SEQ_EPS_EN
// PORTS
// clk          in   1          clock, rising edge
// rst_n        in   1          async active-low reset
// start        in   1          begin a row; honoured only in IDLE
// in_valid     in   1          activation stream valid
// in_data      in   X_WIDTH    activation x (signed)
// in_ready     out  1          high only in LOAD
// var_req      out  1          request to rsqrt unit, held until var_ack
// var_out      out  VAR_WIDTH  variance (+EPS); stable while var_req=1
// var_ack      in   1          one-cycle pulse; inv_std_in valid in the same cycle
// inv_std_in   in   INV_WIDTH  1/sqrt(var), S9.14
// gb_addr      out  LOG2_N     gamma/beta ROM address; data returns 1 cycle later
// gamma_in     in   8          gamma[gb_addr of previous cycle], S1.6
// beta_in      in   8          beta[gb_addr of previous cycle], S1.6
// pe_valid     out  1          to PE valid_in_pe
// pe_x         out  X_WIDTH    to PE x_i_in
// pe_mu        out  MU_WIDTH   to PE mu_common_in
// pe_inv_std   out  INV_WIDTH  to PE inv_std_eff_common_in
// pe_gamma     out  8          to PE gamma_i_in
// pe_beta      out  8          to PE beta_i_in
// pe_valid_out in   1          from PE valid_out_pe
// busy         out  1          high in every state except IDLE
// done         out  1          one-cycle pulse when the N-th PE result arrives
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, including in_ready, var_req, pe_valid, done and
//   busy; counters and accumulators 0. Reset mid-row aborts the row; no done is issued.
// - FSM: IDLE -start-> LOAD -N accepted-> STATS (1 cycle) -> RSQRT -var_ack-> STREAM
//   -N issued-> DRAIN -N results-> IDLE, with done pulsed on the transition to IDLE.
// - LOAD: accept x on in_valid&in_ready and write it to buf[cnt]. sum += sext(x) (38b);
//   sumsq += x*x (signed 32b product, 38b accumulator). After N beats, in_ready drops
//   the next cycle.
// - STATS: mu = sum>>>LOG2_N, truncated to MU_WIDTH.
//   var = (sumsq>>LOG2_N) - mu*mu, both at frac 20. A negative result clamps to 0;
//   a result above 2^VAR_WIDTH-1 saturates.
// - RSQRT: var_req=1 and var_out held. On var_ack, latch inv_std_in and drop var_req
//   the next cycle.
// - STREAM: gb_addr = i for i = 0..N-1, one per cycle.
//   The next cycle: pe_valid=1, pe_x=buf[i], pe_gamma/pe_beta = ROM data.
//   pe_mu and pe_inv_std are constant for the whole row. Exactly N pe_valid beats,
//   back-to-back, no gaps.
// - DRAIN: count pe_valid_out (counting also runs during STREAM). done fires when the
//   count reaches N, which is PE_LAT cycles after the last pe_valid. pe_valid_out seen
//   in IDLE is ignored.
// - start while busy is ignored. in_valid outside LOAD is not consumed.
//   var_ack outside RSQRT is ignored.
// - Counters are LOG2_N+1 bits, so the terminal count N does not wrap.
// CONFIGURATION
// - `define LN_SEQ_EPS_EN: var_out = sat(var + EPS). rsqrt never sees 0, so a constant
//   row yields a finite inv_std.
// - Without it: var_out = var exactly. A constant row sends var_out=0, and the rsqrt
//   unit owns the result.
// TESTING (LOG2_N=2, N=4, PE_LAT=6)
// - x={1.0,-1.0,1.0,-1.0} (0x0400,0xFC00,..) -> mu=0x000000, var_out=0x00100000;
//   ack inv=0x004000 -> 4 pe_valid beats, done.
// - x={1.0 x4} -> var_out=0x00000000, or 0x00000001 with LN_SEQ_EPS_EN;
//   pe_mu=0x000400 on all beats.
// - gamma ROM {0x40,0x20,0x10,0x08} -> pe_gamma on beats 0..3 matches in order
//   (1-cycle ROM latency aligned).
// - in_valid toggling 1,0,1,1,0,1 -> exactly 4 beats accepted; in_ready=0 after the
//   4th; start during STREAM ignored.
// - Hold var_ack low 20 cycles -> var_req and var_out stable, pe_valid=0; ack ->
//   first pe_valid 2 cycles later.
// - Assert rst_n low during STREAM beat 2 -> all outputs 0 asynchronously, IDLE;
//   a new row after reset completes with correct mu.

Source files
------------

// File: rtl/layer_norm_row_sequencer.sv
// Layer-norm row controller: buffers one row, forms mean/variance, fetches inv_std
// from the rsqrt unit, then streams the row into the PE. `LN_SEQ_EPS_EN adds EPS to var_out.
module layer_norm_row_sequencer #(
    parameter int X_WIDTH   = 16,
    parameter int MU_WIDTH  = 24,
    parameter int INV_WIDTH = 24,
    parameter int VAR_WIDTH = 32,
    parameter int LOG2_N    = 6,
    parameter int PE_LAT    = 6,
    parameter int EPS       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [X_WIDTH-1:0]   in_data,
    output logic                 in_ready,
    output logic                 var_req,
    output logic [VAR_WIDTH-1:0] var_out,
    input  logic                 var_ack,
    input  logic [INV_WIDTH-1:0] inv_std_in,
    output logic [LOG2_N-1:0]    gb_addr,
    input  logic [7:0]           gamma_in,
    input  logic [7:0]           beta_in,
    output logic                 pe_valid,
    output logic [X_WIDTH-1:0]   pe_x,
    output logic [MU_WIDTH-1:0]  pe_mu,
    output logic [INV_WIDTH-1:0] pe_inv_std,
    output logic [7:0]           pe_gamma,
    output logic [7:0]           pe_beta,
    input  logic                 pe_valid_out,
    output logic                 busy,
    output logic                 done
);

    localparam int N     = 1 << LOG2_N;
    localparam int CW    = LOG2_N + 1;
    localparam int SUM_W = 38;
    localparam int SQ_W  = 2 * X_WIDTH;
    localparam int MSQ_W = 2 * MU_WIDTH;
    localparam int DW    = ((SUM_W > MSQ_W) ? SUM_W : MSQ_W) + 2;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [DW-1:0] VAR_MAX = {{(DW-VAR_WIDTH){1'b0}}, {VAR_WIDTH{1'b1}}};
`ifdef LN_SEQ_EPS_EN
    localparam logic [DW-1:0] EPS_ADD = DW'(EPS);
`else
    localparam logic [DW-1:0] EPS_ADD = '0;
`endif

    if (LOG2_N < 1 || PE_LAT < 1 || EPS < 0) begin : g_bad_param
        $error("layer_norm_row_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STATS, S_RSQRT, S_STREAM, S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]           cnt_q, res_q;
    logic signed [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0]        sumsq_q;
    logic [MU_WIDTH-1:0]     mu_q;
    logic [VAR_WIDTH-1:0]    var_q;
    logic [INV_WIDTH-1:0]    inv_q;
    logic [X_WIDTH-1:0]      row_buf [N];
    logic                    pe_valid_q;
    logic [X_WIDTH-1:0]      pe_x_q;

    logic accept, load_last, issue, issue_last, res_inc, row_done;

    assign accept     = (state_q == S_LOAD) && in_valid;
    assign load_last  = accept && (cnt_q == LAST);
    assign issue      = (state_q == S_STREAM);
    assign issue_last = issue && (cnt_q == LAST);
    assign res_inc    = pe_valid_out && ((state_q == S_STREAM) || (state_q == S_DRAIN));
    assign row_done   = (state_q == S_DRAIN) && pe_valid_out && (res_q == LAST);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)      state_d = S_LOAD;
            S_LOAD:   if (load_last)  state_d = S_STATS;
            S_STATS:                  state_d = S_RSQRT;
            S_RSQRT:  if (var_ack)    state_d = S_STREAM;
            S_STREAM: if (issue_last) state_d = S_DRAIN;
            S_DRAIN:  if (row_done)   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_LOAD);
        var_req  = (state_q == S_RSQRT);
        busy     = (state_q != S_IDLE);
        done     = row_done;
        gb_addr  = issue ? cnt_q[LOG2_N-1:0] : '0;
    end

    // Statistics: mean at frac 10, variance at frac 20, clamped into the unsigned VAR range.
    logic signed [MU_WIDTH-1:0] mu_c;
    logic signed [MSQ_W-1:0]    mu_sq;
    logic signed [DW-1:0]       diff;
    logic [DW-1:0]              var_pos, var_eps;
    logic [VAR_WIDTH-1:0]       var_c;
    logic signed [SQ_W-1:0]     sq;

    always_comb begin
        sq      = $signed(in_data) * $signed(in_data);
        mu_c    = MU_WIDTH'(sum_q >>> LOG2_N);
        mu_sq   = mu_c * mu_c;
        diff    = $signed(DW'(sumsq_q >> LOG2_N)) - $signed(DW'(mu_sq));
        var_pos = diff[DW-1] ? '0 : $unsigned(diff);
        var_eps = var_pos + EPS_ADD;
        var_c   = (var_eps > VAR_MAX) ? '1 : var_eps[VAR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            res_q      <= '0;
            sum_q      <= '0;
            sumsq_q    <= '0;
            mu_q       <= '0;
            var_q      <= '0;
            inv_q      <= '0;
            pe_valid_q <= 1'b0;
            pe_x_q     <= '0;
        end else begin
            pe_valid_q <= issue;
            if (issue) pe_x_q <= row_buf[cnt_q[LOG2_N-1:0]];
            if (res_inc) res_q <= res_q + CW'(1);
            unique case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    res_q   <= '0;
                    sum_q   <= '0;
                    sumsq_q <= '0;
                end
                S_LOAD: if (accept) begin
                    cnt_q   <= load_last ? '0 : cnt_q + CW'(1);
                    sum_q   <= sum_q + SUM_W'($signed(in_data));
                    sumsq_q <= sumsq_q + SUM_W'($unsigned(sq));
                end
                S_STATS: begin
                    mu_q  <= mu_c;
                    var_q <= var_c;
                end
                S_RSQRT: if (var_ack) inv_q <= inv_std_in;
                S_STREAM: cnt_q <= issue_last ? '0 : cnt_q + CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) row_buf[cnt_q[LOG2_N-1:0]] <= in_data;
    end

    // ROM data arrives one cycle after gb_addr, aligned with the registered beat.
    assign pe_valid   = pe_valid_q;
    assign pe_x       = pe_x_q;
    assign pe_gamma   = pe_valid_q ? gamma_in : 8'h00;
    assign pe_beta    = pe_valid_q ? beta_in  : 8'h00;
    assign pe_mu      = mu_q;
    assign pe_inv_std = inv_q;
    assign var_out    = var_q;

endmodule

// File: tb/tb_layer_norm_row_sequencer.sv
// Directed bench for layer_norm_row_sequencer with N=4, a 6-cycle PE delay model and a gamma/beta ROM.
module tb_layer_norm_row_sequencer;
    localparam int LOG2_N = 2;
    localparam int N      = 4;
    localparam int PE_LAT = 6;
`ifdef LN_SEQ_EPS_EN
    localparam logic [31:0] EPS_T = 32'd1;
`else
    localparam logic [31:0] EPS_T = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        var_req;
    logic [31:0] var_out;
    logic        var_ack = 1'b0;
    logic [23:0] inv_std_in = '0;
    logic [1:0]  gb_addr;
    logic [7:0]  gamma_in = '0;
    logic [7:0]  beta_in = '0;
    logic        pe_valid;
    logic [15:0] pe_x;
    logic [23:0] pe_mu;
    logic [23:0] pe_inv_std;
    logic [7:0]  pe_gamma;
    logic [7:0]  pe_beta;
    logic        pe_valid_out;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    layer_norm_row_sequencer #(
        .X_WIDTH(16), .MU_WIDTH(24), .INV_WIDTH(24), .VAR_WIDTH(32),
        .LOG2_N(LOG2_N), .PE_LAT(PE_LAT), .EPS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .var_req(var_req), .var_out(var_out), .var_ack(var_ack),
        .inv_std_in(inv_std_in), .gb_addr(gb_addr), .gamma_in(gamma_in), .beta_in(beta_in),
        .pe_valid(pe_valid), .pe_x(pe_x), .pe_mu(pe_mu), .pe_inv_std(pe_inv_std),
        .pe_gamma(pe_gamma), .pe_beta(pe_beta), .pe_valid_out(pe_valid_out),
        .busy(busy), .done(done)
    );

    // PE stand-in: valid delayed by PE_LAT cycles
    logic [PE_LAT-1:0] pe_dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_dly <= '0;
        else        pe_dly <= {pe_dly[PE_LAT-2:0], pe_valid};
    end
    assign pe_valid_out = pe_dly[PE_LAT-1];

    logic [7:0] g_rom [4] = '{8'h40, 8'h20, 8'h10, 8'h08};
    logic [7:0] b_rom [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    always @(posedge clk) begin
        gamma_in <= g_rom[gb_addr];
        beta_in  <= b_rom[gb_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [15:0] m_x   [64];
    logic [7:0]  m_g   [64];
    logic [7:0]  m_b   [64];
    logic [23:0] m_mu  [64];
    logic [23:0] m_inv [64];
    int mon_beats = 0, mon_last = 0, mon_done = 0, mon_done_cyc = 0;
    always @(negedge clk) begin
        if (pe_valid && mon_beats < 64) begin
            m_x[mon_beats]   = pe_x;
            m_g[mon_beats]   = pe_gamma;
            m_b[mon_beats]   = pe_beta;
            m_mu[mon_beats]  = pe_mu;
            m_inv[mon_beats] = pe_inv_std;
            mon_last  = cyc;
            mon_beats = mon_beats + 1;
        end
        if (done) begin
            mon_done     = mon_done + 1;
            mon_done_cyc = cyc;
        end
    end

    int checks = 0;
    int failures = 0;
    int base_beats = 0, base_done = 0;
    logic [15:0] xr [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        base_beats = mon_beats;
        base_done  = mon_done;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic load_row(input logic [15:0] xv [4], input logic [5:0] pat, input int exp_steps);
        int k = 0;
        int p = 0;
        while (k < N && p < 50) begin
            if (pat[p % 6] && in_ready) begin
                in_valid = 1'b1;
                in_data  = xv[k];
                k++;
            end else begin
                in_valid = pat[p % 6];
                in_data  = 16'h1234;
            end
            p++;
            step();
        end
        chk("load_accepted", k, N);
        chk("load_steps", p, exp_steps);
        // junk beat and stray ack while in STATS must both be ignored
        in_valid   = 1'b1;
        in_data    = 16'h7FFF;
        var_ack    = 1'b1;
        inv_std_in = 24'hFFFFFF;
        chk("in_ready_after_load", in_ready, 0);
        step();
        in_valid = 1'b0;
        var_ack  = 1'b0;
    endtask

    task automatic rsqrt_phase(input int hold, input logic [23:0] inv, input logic [31:0] exp_var);
        logic stable = 1'b1;
        chk("rsqrt_var_req", var_req, 1);
        chk("rsqrt_var_out", var_out, exp_var);
        for (int i = 0; i < hold; i++) begin
            step();
            if (var_req !== 1'b1 || var_out !== exp_var || pe_valid !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("rsqrt_hold_stable", stable, 1);
        var_ack    = 1'b1;
        inv_std_in = inv;
        step();
        var_ack    = 1'b0;
        inv_std_in = 24'h0F0F0F;
        chk("ack_var_req_drop", var_req, 0);
        chk("ack_pe_valid_early", pe_valid, 0);
        step();
        chk("first_beat_latency", pe_valid, 1);
    endtask

    task automatic finish_row(input logic [15:0] xv [4], input logic [23:0] inv, input logic [23:0] mu);
        int g = 0;
        while (mon_done == base_done && g < 60) begin
            step();
            g++;
        end
        chk("done_seen", mon_done, base_done + 1);
        chk("beat_count", mon_beats, base_beats + N);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("pe_x[%0d]", k), m_x[base_beats+k], xv[k]);
            chk($sformatf("pe_gamma[%0d]", k), m_g[base_beats+k], g_rom[k]);
            chk($sformatf("pe_beta[%0d]", k), m_b[base_beats+k], b_rom[k]);
            chk($sformatf("pe_mu[%0d]", k), m_mu[base_beats+k], mu);
            chk($sformatf("pe_inv[%0d]", k), m_inv[base_beats+k], inv);
        end
        chk("done_latency", mon_done_cyc - mon_last, PE_LAT);
        step();
        step();
        chk("done_single_pulse", mon_done, base_done + 1);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_var_req", var_req, 0);
        chk("rst_pe_valid", pe_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_var_out", var_out, 0);
        chk("rst_gb_addr", gb_addr, 0);
        rst_n = 1'b1;
        step();

        // stray ack in IDLE
        var_ack    = 1'b1;
        inv_std_in = 24'hFFFFFF;
        step();
        var_ack = 1'b0;
        chk("idle_ack_ignored", var_req, 0);

        // Row A: +/-1.0 alternating
        xr = '{16'h0400, 16'hFC00, 16'h0400, 16'hFC00};
        do_start();
        load_row(xr, 6'b111111, 4);
        rsqrt_phase(2, 24'h004000, 32'h00100000 + EPS_T);
        finish_row(xr, 24'h004000, 24'h000000);

        // Row B: constant 1.0, gapped input, long ack wait, start during STREAM
        xr = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        do_start();
        load_row(xr, 6'b101101, 6);
        rsqrt_phase(20, 24'h123456, 32'h00000000 + EPS_T);
        start = 1'b1;
        step();
        start = 1'b0;
        finish_row(xr, 24'h123456, 24'h000400);

        // Row C: reset during STREAM beat 2
        xr = '{16'h0800, 16'h0C00, 16'h0400, 16'h0000};
        do_start();
        load_row(xr, 6'b111111, 4);
        rsqrt_phase(0, 24'h002000, 32'h00140000 + EPS_T);
        step();
        step();
        chk("beat2_valid", pe_valid, 1);
        chk("beat2_x", pe_x, 16'h0400);
        rst_n = 1'b0;
        #1;
        chk("arst_pe_valid", pe_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pe_x", pe_x, 0);
        chk("arst_pe_mu", pe_mu, 0);
        chk("arst_pe_inv", pe_inv_std, 0);
        chk("arst_pe_gamma", pe_gamma, 0);
        chk("arst_pe_beta", pe_beta, 0);
        chk("arst_var_out", var_out, 0);
        chk("arst_gb_addr", gb_addr, 0);
        chk("arst_done", done, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("abort_no_done", mon_done, base_done);
        chk("abort_idle", busy, 0);

        // Row D: negative values after reset
        xr = '{16'hF800, 16'hF400, 16'hFC00, 16'hF000};
        do_start();
        load_row(xr, 6'b111111, 4);
        rsqrt_phase(1, 24'h00ABCD, 32'h00140000 + EPS_T);
        finish_row(xr, 24'h00ABCD, 24'hFFF600);

        // Row E: floor of mean makes raw variance negative -> clamp to 0
        xr = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        do_start();
        load_row(xr, 6'b111111, 4);
        rsqrt_phase(0, 24'h7FFFFF, 32'h00000000 + EPS_T);
        finish_row(xr, 24'h7FFFFF, 24'hFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
